del_cal_sequencer: RTL and testbench
====================================

Name: del_cal_sequencer

Overview:
- Automates DAC delay calibration: takes ownership of the 32-bit GPIO config bus, writes the DAC mux-select register to delay-cal mode, then sweeps the shift-amount register.
- For each shift value it pulses del_trig, dwells, and strobes a sample marker so a capture block can record the ADC response.
- Restores mux-select to a host-chosen value at the end.
- Sits between the PS GPIO and the DAC driver; in idle the host bus passes through unchanged.

Parameters:
- MUX_SEL_ADDR, 3, GPIO address of the DAC mux-select register.
- SHIFT_AMT_ADDR, 4, GPIO address of the shift-amount register.
- DEL_CAL_SEL, 2, mux-select value that selects the delay-cal word.
- WR_HOLD, 2, cycles w_clk (bit 24) is held high per write, minimum 1.
- DWELL_CYCLES, 64, cycles waited after each del_trig pulse, minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- gpio_host_in  in  32  PS GPIO bus: [15:0] addr, [23:16] data, [24] w_clk
- gpio_out  out  32  arbitrated GPIO bus to the DAC driver config registers
- start  in  1  single-cycle sweep request
- shift_start  in  8  first shift value, sampled on accepted start
- shift_count  in  8  number of shift steps, sampled on accepted start
- restore_sel  in  8  mux-select value written at sweep end, sampled on accepted start
- del_trig  out  1  one-cycle trigger to delay-cal driver
- sample_strobe  out  1  one-cycle pulse at end of each dwell
- cur_shift  out  8  shift value currently applied
- busy  out  1  high while sequencer owns the bus
- done  out  1  one-cycle pulse on sweep completion
- host_collision  out  1  sticky; set when host toggles w_clk while busy

Behaviour:
- Reset (async, immediate): state IDLE, gpio_out = gpio_host_in (passthrough), del_trig/sample_strobe/done/busy/host_collision = 0, cur_shift = 0.
- Bus ownership:
  - IDLE: gpio_out is combinational passthrough.
  - Otherwise gpio_out = {7'b0, wclk_r, data_r, addr_r}, all registered.
- Write sub-sequence, 2+WR_HOLD cycles (4 at default):
  - SETUP: addr/data driven, w_clk = 0, 1 cycle.
  - STROBE: w_clk = 1, WR_HOLD cycles.
  - RELEASE: w_clk = 0, 1 cycle.
- start is accepted only in IDLE; start while busy is ignored.
- Accepted start with shift_count == 0: done pulses the next cycle; busy stays 0; no bus activity.
- Main FSM:
  - IDLE -> WR_SEL on accepted start; busy rises the cycle after start.
  - WR_SEL: write DEL_CAL_SEL to MUX_SEL_ADDR -> WR_SHIFT.
  - WR_SHIFT: write cur_shift to SHIFT_AMT_ADDR -> TRIG.
  - TRIG: del_trig = 1 for 1 cycle -> DWELL.
  - DWELL: count DWELL_CYCLES; sample_strobe = 1 on the last cycle. Then either:
    - steps remaining: cur_shift <= cur_shift+1 (mod 256, wraps 255->0) -> WR_SHIFT;
    - otherwise -> WR_RESTORE.
  - WR_RESTORE: write restore_sel to MUX_SEL_ADDR -> DONE.
  - DONE: done = 1 for 1 cycle; busy drops the same cycle; passthrough resumes the next cycle -> IDLE.
- Cycle counts:
  - cur_shift loads shift_start on start acceptance.
  - Number of del_trig pulses = shift_count (1..255).
- Handoff glitch guard:
  - On entering IDLE, if gpio_host_in[24] = 1, gpio_out[24] is forced 0 until the host drops it. This prevents a false write edge.
- host_collision:
  - Set when gpio_host_in[24] rises while busy.
  - Cleared only by reset, or by the host writing address 0xFFFF with w_clk while idle (that write is also passed through).
- Reset mid-sweep:
  - Returns to passthrough immediately.
  - Downstream registers keep their last written values (mux-select is NOT restored).

Optional Feature:
- Macro: DEL_CAL_SEQ_ABORT_EN.
- With it: extra input abort (1 bit).
  - Abort high in any state except IDLE/DONE: any in-flight write completes its RELEASE, then the FSM jumps to WR_RESTORE, then DONE.
  - Abort during WR_RESTORE is ignored.
  - No further del_trig or sample_strobe after the abort is sampled.
- Without it: no abort port; a sweep always runs to completion.

Test Plan:
- Idle passthrough: drive gpio_host_in = 0x0103_0004 -> gpio_out equals it the same cycle; busy = 0.
- Basic sweep (shift_start=5, shift_count=3, restore_sel=0):
  - Bus writes are (3,2), (4,5), (4,6), (4,7), (3,0).
  - 3 del_trig pulses, each followed by sample_strobe exactly 64 cycles later.
  - cur_shift 5,6,7; one done pulse.
- Wrap: shift_start=254, shift_count=3 -> shift writes 254, 255, 0.
- Zero count: shift_count=0 -> done one cycle after start; gpio_out[24] never toggles under sequencer control.
- Collision/glitch:
  - Host toggles w_clk mid-sweep -> host_collision = 1 and no host data appears on gpio_out.
  - Host holds w_clk high at sweep end -> gpio_out[24] stays 0 until the host releases it.
- Async reset mid-DWELL: rst asserted -> busy/del_trig drop without a clock edge; passthrough restored; a second start behaves like a fresh sweep.

Source files
------------

// File: rtl/del_cal_sequencer.sv
// Delay-calibration sequencer: takes over the GPIO config bus, selects delay-cal mode, then sweeps the shift amount.
// Optional abort input is enabled by defining DEL_CAL_SEQ_ABORT_EN.
module del_cal_sequencer #(
  parameter logic [15:0] MUX_SEL_ADDR   = 16'd3,
  parameter logic [15:0] SHIFT_AMT_ADDR = 16'd4,
  parameter logic [7:0]  DEL_CAL_SEL    = 8'd2,
  parameter int unsigned WR_HOLD        = 2,
  parameter int unsigned DWELL_CYCLES   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_host_in,
  output logic [31:0] gpio_out,
  input  logic        start,
  input  logic [7:0]  shift_start,
  input  logic [7:0]  shift_count,
  input  logic [7:0]  restore_sel,
  output logic        del_trig,
  output logic        sample_strobe,
  output logic [7:0]  cur_shift,
  output logic        busy,
  output logic        done,
  output logic        host_collision
`ifdef DEL_CAL_SEQ_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_SEL     = 3'd1;
  localparam logic [2:0] S_WR_SHIFT   = 3'd2;
  localparam logic [2:0] S_TRIG       = 3'd3;
  localparam logic [2:0] S_DWELL      = 3'd4;
  localparam logic [2:0] S_WR_RESTORE = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam logic [1:0] PH_SETUP   = 2'd0;
  localparam logic [1:0] PH_STROBE  = 2'd1;
  localparam logic [1:0] PH_RELEASE = 2'd2;

  localparam logic [15:0] HOLD_LAST  = 16'(WR_HOLD - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cur_shift_q, cur_shift_d;
  logic [7:0]  steps_q, steps_d;
  logic [7:0]  restore_q, restore_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wclk_q, wclk_d;
  logic        del_trig_q, sample_strobe_q, done_q, busy_q;
  logic        coll_q, coll_d;
  logic        guard_q, guard_d;
  logic        host_wclk_q;
  logic        zero_done_s;
  logic        abort_pend_s;

`ifdef DEL_CAL_SEQ_ABORT_EN
  logic abort_q, abort_d;
  // An abort is remembered until the in-flight write has released, then steers to the restore write.
  assign abort_pend_s = abort_q | (abort & (state_q inside {S_WR_SEL, S_WR_SHIFT, S_TRIG, S_DWELL}));
  assign abort_d      = abort_pend_s & (state_d inside {S_WR_SEL, S_WR_SHIFT, S_TRIG, S_DWELL});

  // Abort latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) abort_q <= 1'b0;
    else     abort_q <= abort_d;
  end
`else
  assign abort_pend_s = 1'b0;
`endif

  // Sweep FSM and write sub-sequence next-state logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    cur_shift_d = cur_shift_q;
    steps_d     = steps_q;
    restore_d   = restore_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wclk_d      = wclk_q;
    zero_done_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_shift_d = shift_start;
          steps_d     = shift_count;
          restore_d   = restore_sel;
          if (shift_count == 8'd0) zero_done_s = 1'b1;
          else                     state_d     = S_WR_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_SEL, S_WR_SHIFT, S_WR_RESTORE: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_STROBE;
            wclk_d  = 1'b1;
            cnt_d   = 16'd0;
          end
          PH_STROBE: begin
            if (cnt_q == HOLD_LAST) begin
              phase_d = PH_RELEASE;
              wclk_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          default: begin
            if (state_q == S_WR_RESTORE) state_d = S_DONE;
            else if (abort_pend_s)       state_d = S_WR_RESTORE;
            else if (state_q == S_WR_SEL) state_d = S_WR_SHIFT;
            else                         state_d = S_TRIG;
          end
        endcase
      end
      S_TRIG: begin
        if (abort_pend_s) state_d = S_WR_RESTORE;
        else              state_d = S_DWELL;
      end
      S_DWELL: begin
        if (abort_pend_s) begin
          state_d = S_WR_RESTORE;
        end else if (cnt_q == DWELL_LAST) begin
          if (steps_q > 8'd1) begin
            steps_d     = steps_q - 8'd1;
            cur_shift_d = cur_shift_q + 8'd1;
            state_d     = S_WR_SHIFT;
          end else begin
            state_d = S_WR_RESTORE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Every state entry starts a fresh counter; write states also load their address/data in SETUP.
    if (state_d != state_q) begin
      phase_d = PH_SETUP;
      cnt_d   = 16'd0;
      wclk_d  = 1'b0;
      case (state_d)
        S_WR_SEL:     begin addr_d = MUX_SEL_ADDR;   data_d = DEL_CAL_SEL; end
        S_WR_SHIFT:   begin addr_d = SHIFT_AMT_ADDR; data_d = cur_shift_d; end
        S_WR_RESTORE: begin addr_d = MUX_SEL_ADDR;   data_d = restore_d;   end
        default:      begin addr_d = addr_q;         data_d = data_q;      end
      endcase
    end else begin
      state_d = state_d;
    end
  end

  // Collision flag and handoff glitch guard next-state logic
  always_comb begin
    coll_d  = coll_q;
    guard_d = guard_q;
    if (busy_q && gpio_host_in[24] && !host_wclk_q) begin
      coll_d = 1'b1;
    end else if (state_q == S_IDLE && gpio_host_in[24] && gpio_host_in[15:0] == 16'hFFFF) begin
      coll_d = 1'b0;
    end else begin
      coll_d = coll_q;
    end
    if (state_q != S_IDLE && state_d == S_IDLE && gpio_host_in[24]) begin
      guard_d = 1'b1;
    end else if (!gpio_host_in[24]) begin
      guard_d = 1'b0;
    end else begin
      guard_d = guard_q;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      phase_q         <= PH_SETUP;
      cnt_q           <= 16'd0;
      cur_shift_q     <= 8'd0;
      steps_q         <= 8'd0;
      restore_q       <= 8'd0;
      addr_q          <= 16'd0;
      data_q          <= 8'd0;
      wclk_q          <= 1'b0;
      del_trig_q      <= 1'b0;
      sample_strobe_q <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      coll_q          <= 1'b0;
      guard_q         <= 1'b0;
      host_wclk_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      cnt_q           <= cnt_d;
      cur_shift_q     <= cur_shift_d;
      steps_q         <= steps_d;
      restore_q       <= restore_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      wclk_q          <= wclk_d;
      del_trig_q      <= (state_d == S_TRIG);
      sample_strobe_q <= (state_d == S_DWELL) && (cnt_d == DWELL_LAST);
      done_q          <= (state_d == S_DONE) || zero_done_s;
      busy_q          <= (state_d != S_IDLE) && (state_d != S_DONE);
      coll_q          <= coll_d;
      guard_q         <= guard_d;
      host_wclk_q     <= gpio_host_in[24];
    end
  end

  // Bus mux: idle is a live passthrough with the handoff guard masking a held w_clk
  always_comb begin
    if (state_q == S_IDLE) begin
      gpio_out     = gpio_host_in;
      gpio_out[24] = gpio_host_in[24] & ~guard_q;
    end else begin
      gpio_out = {7'b0, wclk_q, data_q, addr_q};
    end
  end

  assign del_trig       = del_trig_q;
  assign sample_strobe  = sample_strobe_q;
  assign cur_shift      = cur_shift_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign host_collision = coll_q;

endmodule

// File: tb/tb_del_cal_sequencer.sv
// Directed bench for del_cal_sequencer: idle passthrough table plus hand-written sweep, wrap, collision and reset sequences.
module tb_del_cal_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_host_in;
  logic [31:0] gpio_out;
  logic        start;
  logic [7:0]  shift_start, shift_count, restore_sel;
  logic        del_trig, sample_strobe, busy, done, host_collision;
  logic [7:0]  cur_shift;

  int n_vec = 0;
  int n_bad = 0;

  del_cal_sequencer dut (
    .clk(clk), .rst(rst), .gpio_host_in(gpio_host_in), .gpio_out(gpio_out),
    .start(start), .shift_start(shift_start), .shift_count(shift_count),
    .restore_sel(restore_sel), .del_trig(del_trig), .sample_strobe(sample_strobe),
    .cur_shift(cur_shift), .busy(busy), .done(done), .host_collision(host_collision)
  );

  always #5 clk = ~clk;

  // Event log gathered on the falling edge
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          trig_t[$];
  logic [7:0]  trig_sh[$];
  int          strobe_t[$];
  int          cyc = 0;
  int          done_n = 0;
  logic        prev_w = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (busy && gpio_out[24] && !prev_w) begin
        wr_addr.push_back(gpio_out[15:0]);
        wr_data.push_back(gpio_out[23:16]);
      end
      if (del_trig) begin
        trig_t.push_back(cyc);
        trig_sh.push_back(cur_shift);
      end
      if (sample_strobe) strobe_t.push_back(cyc);
      if (done) done_n = done_n + 1;
    end
    prev_w = gpio_out[24];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete();
    trig_t.delete(); trig_sh.delete(); strobe_t.delete();
  endtask

  task automatic start_sweep(input logic [7:0] s, input logic [7:0] c, input logic [7:0] r);
    @(negedge clk);
    shift_start = s; shift_count = c; restore_sel = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (done !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_trig(input string name);
    int k = 0;
    while (del_trig !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (del_trig !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL %s: del_trig not seen within 100 cycles", name);
    end
  endtask

  task automatic check_writes(input string tag, input int n, input logic [23:0] ew [5]);
    chk({tag, " nwrites"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wr_addr.size()) chk($sformatf("%s wr%0d", tag, i), {8'h0, wr_data[i], wr_addr[i]}, {8'h0, ew[i]});
    end
  endtask

  task automatic check_trigs(input string tag, input logic [7:0] s0, input int n);
    logic [7:0] es;
    es = s0;
    chk({tag, " ntrig"}, 32'(trig_t.size()), 32'(n));
    chk({tag, " nstrobe"}, 32'(strobe_t.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < trig_t.size() && i < strobe_t.size()) begin
        chk($sformatf("%s shift%0d", tag, i), {24'h0, trig_sh[i]}, {24'h0, es});
        chk($sformatf("%s dwell%0d", tag, i), 32'(strobe_t[i] - trig_t[i]), 32'd64);
      end
      es = es + 8'd1;
    end
  endtask

  task automatic basic_sweep(input string tag);
    logic [23:0] ew [5];
    int d0;
    ew = '{24'h02_0003, 24'h05_0004, 24'h06_0004, 24'h07_0004, 24'h00_0003};
    clear_log();
    d0 = done_n;
    start_sweep(8'd5, 8'd3, 8'd0);
    chk({tag, " busy rise"}, {31'h0, busy}, 32'd1);
    wait_done(tag, 2000);
    chk({tag, " busy at done"}, {31'h0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, " done pulses"}, 32'(done_n - d0), 32'd1);
    chk({tag, " idle passthrough"}, gpio_out, gpio_host_in);
    check_writes(tag, 5, ew);
    check_trigs(tag, 8'd5, 3);
  endtask

  typedef struct {
    logic [31:0] host;
    logic [31:0] exp_out;
    logic        exp_busy;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [23:0] ew [5];
    vt[0] = '{32'h0103_0004, 32'h0103_0004, 1'b0};
    vt[1] = '{32'h00FF_1234, 32'h00FF_1234, 1'b0};
    vt[2] = '{32'h01AB_0003, 32'h01AB_0003, 1'b0};
    vt[3] = '{32'hFE00_0000, 32'hFE00_0000, 1'b0};
    vt[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; gpio_host_in = 32'h0077_0005;
    shift_start = 8'd0; shift_count = 8'd0; restore_sel = 8'd0;
    #3;
    chk("reset passthrough", gpio_out, 32'h0077_0005);
    chk("reset busy", {31'h0, busy}, 32'd0);
    chk("reset del_trig", {31'h0, del_trig}, 32'd0);
    chk("reset done", {31'h0, done}, 32'd0);
    chk("reset collision", {31'h0, host_collision}, 32'd0);
    chk("reset cur_shift", {24'h0, cur_shift}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      gpio_host_in = vt[i].host;
      #1;
      chk($sformatf("idle vec%0d out", i), gpio_out, vt[i].exp_out);
      chk($sformatf("idle vec%0d busy", i), {31'h0, busy}, {31'h0, vt[i].exp_busy});
    end
    gpio_host_in = 32'h0000_0000;

    basic_sweep("basic");

    ew = '{24'h02_0003, 24'hFE_0004, 24'hFF_0004, 24'h00_0004, 24'h00_0003};
    clear_log();
    start_sweep(8'd254, 8'd3, 8'd0);
    wait_done("wrap", 2000);
    repeat (2) @(negedge clk);
    #1;
    check_writes("wrap", 5, ew);
    check_trigs("wrap", 8'd254, 3);

    clear_log();
    gpio_host_in = 32'h0000_1234;
    start_sweep(8'd9, 8'd0, 8'd1);
    chk("zero done", {31'h0, done}, 32'd1);
    chk("zero busy", {31'h0, busy}, 32'd0);
    chk("zero out", gpio_out, 32'h0000_1234);
    @(negedge clk); #1;
    chk("zero done drop", {31'h0, done}, 32'd0);
    chk("zero cur_shift", {24'h0, cur_shift}, 32'd9);
    repeat (3) begin
      @(negedge clk); #1;
      chk("zero passthrough", gpio_out, 32'h0000_1234);
    end
    chk("zero ntrig", 32'(trig_t.size()), 32'd0);

    clear_log();
    gpio_host_in = 32'h0000_0004;
    start_sweep(8'd1, 8'd1, 8'd9);
    wait_trig("collision");
    repeat (5) @(negedge clk);
    gpio_host_in = 32'h0155_0004;
    @(negedge clk); #1;
    chk("coll bus owned", gpio_out, 32'h0001_0004);
    chk("coll flag", {31'h0, host_collision}, 32'd1);
    wait_done("collision", 500);
    ew = '{24'h02_0003, 24'h01_0004, 24'h09_0003, 24'h00_0000, 24'h00_0000};
    check_writes("coll", 3, ew);
    @(negedge clk); #1;
    chk("guard first idle", gpio_out, 32'h0055_0004);
    @(negedge clk); #1;
    chk("guard held", gpio_out, 32'h0055_0004);
    gpio_host_in = 32'h0055_0004;
    @(negedge clk);
    gpio_host_in = 32'h0166_0004;
    #1;
    chk("guard released", gpio_out, 32'h0166_0004);
    chk("coll sticky", {31'h0, host_collision}, 32'd1);
    @(negedge clk);
    gpio_host_in = 32'h0100_FFFF;
    #1;
    chk("clear write pass", gpio_out, 32'h0100_FFFF);
    @(negedge clk); #1;
    chk("coll cleared", {31'h0, host_collision}, 32'd0);
    gpio_host_in = 32'h0042_0007;

    clear_log();
    start_sweep(8'd5, 8'd2, 8'd0);
    wait_trig("reset");
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy", {31'h0, busy}, 32'd0);
    chk("rst del_trig", {31'h0, del_trig}, 32'd0);
    chk("rst passthrough", gpio_out, 32'h0042_0007);
    chk("rst cur_shift", {24'h0, cur_shift}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    basic_sweep("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
